// File: rtl/add_seq_ctrl_pkg.sv
// Shared constants for the chunked wide-add sequencer.
// Slice width and controller state encodings.
package add_seq_ctrl_pkg;

   localparam int NBIT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/add_seq_ctrl_slice.sv
// One NBIT-wide adder slice with carry in and carry out.
// Purely combinational; shared by every chunk of the sequencer.
module add_slice_cin
   import add_seq_ctrl_pkg::*;
(
   input  logic [NBIT-1:0] a,
   input  logic [NBIT-1:0] b,
   input  logic            cin,
   output logic [NBIT-1:0] s,
   output logic            cout
);

   logic [NBIT:0] t;

   assign t = {1'b0, a} + {1'b0, b} + {{NBIT{1'b0}}, cin};
   assign {cout, s} = t;

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide adder sequencer: one NBIT chunk per cycle, LSB first,
// through a single shared slice, with valid/ready on both sides.
module add_seq_ctrl
   import add_seq_ctrl_pkg::*;
#(
   parameter int NCHUNK = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NCHUNK*NBIT-1:0] a,
   input  logic [NCHUNK*NBIT-1:0] b,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NCHUNK*NBIT-1:0] sum,
   output logic                   cout,
   output logic                   busy
);

   localparam int CW = $clog2(NCHUNK);
   localparam int W  = NCHUNK * NBIT;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_t          state;
   logic [CW-1:0]   idx;
   logic            carry;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [NBIT-1:0] sl_a;
   logic [NBIT-1:0] sl_b;
   logic [NBIT-1:0] sl_s;
   logic            sl_co;

   assign sl_a = a_q[idx*NBIT +: NBIT];
   assign sl_b = b_q[idx*NBIT +: NBIT];

   add_slice_cin u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry),
      .s    (sl_s),
      .cout (sl_co)
   );

   assign in_ready = (state == ST_IDLE);
   assign busy     = (state == ST_RUN) || (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= cin;
                  idx   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum[idx*NBIT +: NBIT] <= sl_s;
               carry <= sl_co;
               idx   <= idx + CW'(1);
               if (idx == LAST) begin
                  cout      <= sl_co;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed and random self-checking bench for add_seq_ctrl.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_add_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        busy;

   int checks = 0;
   int errors = 0;

   add_seq_ctrl #(.NCHUNK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accept on the next edge, scramble inputs, expect result 4 edges later.
   task automatic op(input string tag, input logic [31:0] ta,
                     input logic [31:0] tb, input logic tc,
                     input logic [31:0] es, input logic ec);
      a = ta; b = tb; cin = tc;
      in_valid = 1'b1; out_ready = 1'b1;
      chk({tag, " in_ready"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      a = ~ta; b = ~tb; cin = ~tc;
      chk({tag, " busy"}, busy, 1);
      for (int k = 0; k < 4; k++) begin
         chk({tag, " early_valid"}, out_valid, 0);
         step();
      end
      chk({tag, " out_valid"}, out_valid, 1);
      chk({tag, " sum"}, sum, es);
      chk({tag, " cout"}, cout, ec);
      step();
      chk({tag, " valid_drop"}, out_valid, 0);
      chk({tag, " idle"}, in_ready, 1);
   endtask

   logic [32:0] exp33;
   logic [31:0] ra, rb;
   logic        rc;
   logic        got;
   int          nres;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      step(); step();
      chk("rst in_ready", in_ready, 1);
      chk("rst busy", busy, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst sum", sum, 0);
      chk("rst cout", cout, 0);
      rst_n = 1'b1;

      op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1);
      op("cin_only", 32'h0, 32'h0, 1'b1, 32'h1, 1'b0);
      op("plain", 32'h1234_5678, 32'h1111_1111, 1'b0,
         32'h2345_6789, 1'b0);

      // backpressure
      a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      for (int k = 0; k < 5; k++) begin
         chk("bp out_valid", out_valid, 1);
         chk("bp sum", sum, 32'h0);
         chk("bp cout", cout, 1);
         chk("bp in_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("bp release valid", out_valid, 0);
      chk("bp release ready", in_ready, 1);

      // back-to-back, operands change right after the accept
      a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("b2b in_ready", in_ready, 0);
         step();
      end
      chk("b2b out_valid1", out_valid, 1);
      chk("b2b sum1", sum, 32'h0001_0000);
      chk("b2b cout1", cout, 0);
      step();
      chk("b2b ready at 5", in_ready, 1);
      step();
      chk("b2b accepted at 6", in_ready, 0);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("b2b out_valid2", out_valid, 1);
      chk("b2b sum2", sum, 32'h0);
      chk("b2b cout2", cout, 1);
      step();

      // reset in the second RUN cycle
      a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst in_ready", in_ready, 1);
      chk("mid_rst out_valid", out_valid, 0);
      chk("mid_rst sum", sum, 0);
      chk("mid_rst cout", cout, 0);
      chk("mid_rst busy", busy, 0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("post_rst no_valid", out_valid, 0);
         step();
      end
      op("post_rst", 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1,
         32'h1E1E_1E1F, 1'b0);

      // random regression with consumer stalls
      nres = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
         exp33 = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
         a = ra; b = rb; cin = rc; in_valid = 1'b1; out_ready = 1'b0;
         for (int k = 0; k < 16 && !in_ready; k++) step();
         if (!in_ready) begin
            chk("rnd accept timeout", 0, 1);
            break;
         end
         step();
         in_valid = 1'b0;
         a = $urandom; b = $urandom;
         got = 1'b0;
         for (int k = 0; k < 64 && !got; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
               chk("rnd result", {cout, sum}, exp33);
               got = 1'b1;
               nres++;
            end
            step();
         end
         if (!got) begin
            chk("rnd result timeout", 0, 1);
            break;
         end
      end
      out_ready = 1'b0;
      chk("rnd result count", nres, 1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
- Sequencer that performs a wide addition of NCHUNK*NBIT bits using one shared NBIT-wide adder slice.
- Processes one NBIT chunk per cycle, least-significant chunk first, carrying the slice carry-out into the next chunk.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades area for latency compared with a full-width combinational adder.

Parameters:
NBIT, 8, width of the shared adder slice and of one chunk (taken from the shared constants file)
NCHUNK, 4, number of chunks per operation; must be >= 2
CW, $clog2(NCHUNK), width of the chunk index counter (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  controller can accept operands
a  input  NCHUNK*NBIT  operand A
b  input  NCHUNK*NBIT  operand B
cin  input  1  carry into chunk 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  NCHUNK*NBIT  registered wide sum
cout  output  1  registered carry out of the top chunk
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE; 2-bit encoded state register.
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, idx=0, carry=0
  - sum=0, cout=0, out_valid=0
  - captured operand registers cleared
  - in_ready=1 and busy=0, both decoded from state=IDLE
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge T: capture a, b; set carry=cin, idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice computes {c_o, s_i} = A[idx] + B[idx] + carry, where A[idx] and B[idx] are NBIT-wide chunks.
  - At the edge, the sum register chunk idx takes s_i, carry takes c_o, idx increments.
  - When idx==NCHUNK-1 at the edge: cout takes c_o, out_valid is set, go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: out_valid clears and state goes to IDLE at that edge.
  - out_ready low holds DONE indefinitely.
- Latency: operands accepted at edge T; out_valid rises after edge T+NCHUNK. Minimum initiation interval is NCHUNK+2 cycles.
- Operand isolation: inputs a, b and cin are ignored outside the IDLE accept edge. Captured copies are used, so the producer may change them freely once the request is accepted.
- Arithmetic:
  - Modulo 2^(NCHUNK*NBIT) sum plus carry-out.
  - Result equals {cout,sum} = a + b + cin exactly, with no overflow flag.
- sum chunks not yet written in the current operation retain their previous values while in RUN. Consumers sample sum only when out_valid is high.
- in_valid during RUN/DONE: ignored; the producer holds its request until in_ready.
- Reset during RUN or DONE: the operation is abandoned, no out_valid is produced, and all state returns to its reset values.
- Reset release: the first accept is possible on the first edge after rst_n rises.

Decomposition:
- Shared constants file:
  - NBIT
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
- One sub-module, add_slice_cin: a combinational NBIT ripple/lookahead slice with a cin input and a cout output. The controller instantiates it once.
- Chunk select, FSM, counter and result registers stay in add_seq_ctrl.

Test Plan (NBIT=8, NCHUNK=4):
1. Wrap-around carry: a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> sum=0x00000000, cout=1; out_valid asserted 4 cycles after the accept edge, for exactly 1 cycle.
2. Carry-in only: a=0x00000000, b=0x00000000, cin=1 -> sum=0x00000001, cout=0. Also a=0x12345678, b=0x11111111, cin=0 -> sum=0x23456789, cout=0.
3. Backpressure: a=0x80000000, b=0x80000000 with out_ready=0 for 5 cycles -> out_valid stays 1, sum=0x00000000 and cout=1 stable, in_ready=0 throughout. out_ready=1 -> IDLE next edge, in_ready=1.
4. Back-to-back with operand change: in_valid held high with new operands changed on the cycle after accept -> first result uses the captured values; the second accept occurs exactly 6 cycles after the first.
5. Reset mid-operation: assert rst_n=0 at the second RUN cycle -> immediately in_ready=1, out_valid=0, sum=0, cout=0. No spurious out_valid after release; a new request completes correctly.
6. Random regression: 1000 random a, b, cin with random out_ready stalls -> every {cout,sum} equals a+b+cin, and every accepted request produces exactly one result, in order.
